// File: rtl/xaui_link_ctrl.sv
// XAUI link bring-up controller: sequences transceiver readiness, lane sync and
// core status clearing, then qualifies a stable link before declaring it up.
module xaui_link_ctrl #(
    parameter int LANES          = 4,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 156250,
    parameter int HOLD_CYCLES    = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk156,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_loopback,
    input  logic             cfg_powerdown,
    input  logic             cfg_test_en,
    input  logic [1:0]       cfg_test_sel,
    input  logic             mgt_tx_ready,
    input  logic [LANES-1:0] sync_status,
    input  logic             align_status,
    input  logic [7:0]       status_vector,
    output logic [6:0]       configuration_vector,
    output logic             ready,
    output logic [2:0]       link_state,
    output logic             link_up_pulse,
    output logic             link_down_pulse,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] down_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TX   = 3'd1,
        WAIT_SYNC = 3'd2,
        CLEAR     = 3'd3,
        HOLD      = 3'd4,
        CHECK     = 3'd5,
        UP        = 3'd6
    } state_t;

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [STB_W-1:0]   stable_reg, stable_next;
    logic [HLD_W-1:0]   hold_reg, hold_next;
    logic               good;
    logic               running;
    logic               timeout;
    logic               retry_inc;
    logic               unused_status;

    // Bits 6:2 of the core status carry nothing the controller acts on.
    assign unused_status = ^status_vector[6:2];

    always_comb begin
        good    = (&sync_status) && align_status && status_vector[7]
                  && (status_vector[1:0] == 2'b00);
        running = (state_reg == WAIT_SYNC) || (state_reg == HOLD) || (state_reg == CHECK);
        timeout = running && (timer_reg == TMR_LAST);
    end

    always_comb begin
        state_next = state_reg;
        retry_inc  = 1'b0;
        if (!enable || cfg_powerdown) begin
            state_next = IDLE;
        end else if (!mgt_tx_ready && (state_reg != IDLE) && (state_reg != WAIT_TX)) begin
            state_next = WAIT_TX;
        end else if (timeout) begin
            state_next = CLEAR;
            retry_inc  = 1'b1;
        end else begin
            case (state_reg)
                IDLE:      state_next = WAIT_TX;
                WAIT_TX:   if (mgt_tx_ready) state_next = WAIT_SYNC;
                WAIT_SYNC: if (&sync_status) state_next = CLEAR;
                CLEAR:     state_next = HOLD;
                HOLD:      if (hold_reg == HLD_LAST) state_next = CHECK;
                CHECK:     if (good && (stable_reg == STB_LAST)) state_next = UP;
                UP:        if (!good) state_next = CLEAR;
                default:   state_next = IDLE;
            endcase
        end
    end

    // One timer spans the whole attempt (WAIT_SYNC, or HOLD through CHECK);
    // CLEAR always restarts it, so HOLD and CHECK share a single budget.
    always_comb begin
        timer_next = timer_reg;
        if ((state_next == CLEAR) || ((state_next == WAIT_SYNC) && (state_reg != WAIT_SYNC))) begin
            timer_next = '0;
        end else if (running) begin
            timer_next = timer_reg + 1'b1;
        end
        stable_next = '0;
        if ((state_reg == CHECK) && good) begin
            stable_next = stable_reg + 1'b1;
        end
        hold_next = '0;
        if (state_reg == HOLD) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_reg            <= IDLE;
            timer_reg            <= '0;
            stable_reg           <= '0;
            hold_reg             <= '0;
            configuration_vector <= '0;
            ready                <= 1'b0;
            link_up_pulse        <= 1'b0;
            link_down_pulse      <= 1'b0;
            retry_count          <= '0;
            down_count           <= '0;
        end else begin
            state_reg            <= state_next;
            timer_reg            <= timer_next;
            stable_reg           <= stable_next;
            hold_reg             <= hold_next;
            configuration_vector <= {cfg_test_sel, cfg_test_en, {2{state_reg == CLEAR}},
                                     cfg_powerdown, cfg_loopback};
            ready                <= (state_next == UP);
            link_up_pulse        <= (state_next == UP) && (state_reg != UP);
            link_down_pulse      <= (state_reg == UP) && (state_next != UP);
            if (retry_inc && (retry_count != '1)) begin
                retry_count <= retry_count + 1'b1;
            end
            if ((state_reg == UP) && (state_next != UP) && (down_count != '1)) begin
                down_count <= down_count + 1'b1;
            end
        end
    end

    assign link_state = state_reg;

endmodule
